// File: rtl/mon_pkg.sv
// Shared constants and FSM state type for the monitor register readback path.
package mon_pkg;

  localparam int REG_WIDTH = 32;
  localparam int ADDR_W    = 8;
  localparam int BITCNT_W  = 5;

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

endpackage

// File: rtl/mon_deser32.sv
// MSB-first serial-to-parallel capture with a 5-bit bit counter.
module mon_deser32
  import mon_pkg::*;
(
  input  logic                 bclk,
  input  logic                 rstb,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 serialBit,
  output logic [REG_WIDTH-1:0] word,
  output logic                 lastBit
);

  logic [REG_WIDTH-2:0] capture;
  logic [BITCNT_W-1:0]  bitCnt;

  // The oldest bit would fall out on the final edge, so only 31 bits are stored
  // and word already includes the bit arriving on the current edge.
  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) begin
      capture <= '0;
      bitCnt  <= '0;
    end else if (clear) begin
      capture <= '0;
      bitCnt  <= '0;
    end else if (shift) begin
      capture <= {capture[REG_WIDTH-3:0], serialBit};
      bitCnt  <= bitCnt + BITCNT_W'(1);
    end
  end

  assign word    = {capture, serialBit};
  assign lastBit = (bitCnt == BITCNT_W'(REG_WIDTH - 1));

endmodule

// File: rtl/mon_readout.sv
// Readback master: latches a bank register, shifts it out over 32 cycles, and hands the word to the host.
module mon_readout #(
  parameter int REG_WIDTH = 32,
  parameter int ADDR_W    = 8
) (
  input  logic                 bclk,
  input  logic                 rstb,
  input  logic                 rdReq,
  input  logic [ADDR_W-1:0]    rdAddr,
  output logic                 rdBusy,
  output logic                 rdValid,
  output logic [REG_WIDTH-1:0] rdData,
  output logic                 rdErr,
  input  logic                 rdAck,
  output logic [ADDR_W-1:0]    addrOut,
  output logic                 latchOut,
  output logic                 shiftEn,
  input  logic                 shiftIn,
  input  logic                 serIn
);

  import mon_pkg::*;

  state_t               state;
  state_t               nextState;
  logic [REG_WIDTH-1:0] word;
  logic                 lastBit;

  mon_deser32 deser (
    .bclk      (bclk),
    .rstb      (rstb),
    .clear     (state == LATCH),
    .shift     (state == SHIFT),
    .serialBit (shiftIn),
    .word      (word),
    .lastBit   (lastBit)
  );

  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (rdReq) nextState = LATCH;
      LATCH:   nextState = SHIFT;
      SHIFT:   if (lastBit) nextState = DONE;
      DONE:    if (rdAck) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) begin
      latchOut <= 1'b0;
      shiftEn  <= 1'b0;
      rdBusy   <= 1'b0;
      rdValid  <= 1'b0;
      rdErr    <= 1'b0;
      rdData   <= '0;
      addrOut  <= '0;
    end else begin
      latchOut <= (nextState == LATCH);
      shiftEn  <= (nextState == SHIFT);
      rdBusy   <= (nextState != IDLE);
      rdValid  <= (nextState == DONE);
      if (state == IDLE && rdReq) addrOut <= rdAddr;
      if (state == LATCH) rdErr <= serIn;
      if (state == SHIFT && lastBit) rdData <= word;
    end
  end

endmodule

// File: doc/mon_readout.md
# mon_readout

Readback master for the triplicated monitor/control register bank. On a host read request it issues the one-cycle output latch strobe with the target address on the shared bus. It then drives the shift enable for exactly 32 cycles and deserializes the selected register's MSB-first serial output into a 32-bit word. The word is presented to the host with a valid/acknowledge handshake, together with the bank's soft-error flag sampled at latch time.

## Interface
Parameters:
- REG_WIDTH, 32, serial word length; fixed at 32, bit counter is 5 bits.
- ADDR_W, 8, register address width.

Ports:
- bclk  in  1  clock; all state updates on rising edge.
- rstb  in  1  reset; asynchronous, active-low.
- rdReq  in  1  host read request; sampled only in IDLE.
- rdAddr  in  ADDR_W  register address; captured when rdReq is accepted.
- rdBusy  out  1  high in every state except IDLE.
- rdValid  out  1  rdData/rdErr are valid; held until rdAck.
- rdData  out  32  deserialized register value.
- rdErr  out  1  bank soft-error flag captured during the LATCH cycle.
- rdAck  in  1  host consumed the result; meaningful only while rdValid=1.
- addrOut  out  ADDR_W  address driven to the register bank.
- latchOut  out  1  one-cycle strobe that loads the addressed register's output shifter.
- shiftEn  out  1  shift strobe to the bank's output shifters.
- shiftIn  in  1  serial data from the bank; the OR of all register shift outputs, non-addressed shifters are zero.
- serIn  in  1  OR of all register soft-error outputs.

## Operation
- FSM states: IDLE, LATCH, SHIFT, DONE.
- IDLE
  - When rdReq=1: capture rdAddr into addrOut and go to LATCH.
  - Otherwise stay.
- LATCH
  - latchOut=1 for exactly one cycle.
  - Capture serIn into the error register.
  - Clear the capture shifter and set bitCnt=0.
  - Go to SHIFT.
- SHIFT
  - shiftEn=1 on every cycle.
  - On each edge: capture <= {capture[30:0], shiftIn}, then bitCnt <= bitCnt+1.
  - When bitCnt=31 on an edge: go to DONE, copy the final capture (including that bit) to rdData, and set rdValid=1.
- DONE
  - rdValid held high; rdData/rdErr stable.
  - When rdAck=1: clear rdValid and go to IDLE.
- rdReq outside IDLE is ignored; there is no queueing, and the host must re-request.
- rdAck outside DONE is ignored.
- addrOut is held at the captured address from LATCH until the return to IDLE, so the bank cannot see an address change mid-shift. It keeps that value in IDLE and only changes on the next accepted request.
- Bit order: the first bit captured is register bit 31; rdData[31:0] equals the register's majority-voted value at the LATCH edge.
- Reset (asynchronous, any state including mid-SHIFT):
  - State goes to IDLE.
  - latchOut, shiftEn, rdValid, rdBusy, rdErr and bitCnt go to 0.
  - rdData, addrOut and the capture shifter go to 0.
  - An aborted read produces no rdValid.

## Timing
- All outputs are registered; none has a combinational path from any input.
- Request accepted at edge E0 → latchOut high in cycle E0..E1.
- shiftEn high for E1..E33: exactly 32 cycles.
- rdValid rises at edge E33, giving 33 cycles from request acceptance to valid.
- The earliest rdAck is sampled at E34; IDLE is entered at E34, and the next request can be accepted at E35.
- Minimum read period is 35 cycles with zero-wait acknowledgement.
- shiftEn is never high in the same cycle as latchOut.
- rdBusy is high from E0 through the rdAck edge.

## Structure
- Shared package mon_pkg:
  - REG_WIDTH and ADDR_W constants.
  - State enum {IDLE, LATCH, SHIFT, DONE}.
  - BITCNT_W = 5.
- One sub-module is natural: mon_deser32, holding the capture shifter and 5-bit bit counter.
  - Inputs: clear, shift, serial bit.
  - Outputs: 32-bit word, last-bit flag.
- The FSM, address register and handshake stay in mon_readout.

## Test plan
- Bank model with register 0x12 = 0xDEADBEEF; rdReq with rdAddr=0x12, rdAck tied high → one latchOut pulse with addrOut=0x12, 32 shiftEn cycles, rdValid at +33 cycles with rdData=0xDEADBEEF and rdErr=0.
- Register 0x03 = 0x80000001, with serIn=1 forced during the LATCH cycle only → rdData=0x80000001, rdErr=1.
- rdReq held high during SHIFT with a different rdAddr (0x44) → addrOut stays 0x12, there is no second latchOut, and exactly one read completes.
- rdAck withheld for 10 cycles after rdValid → rdValid, rdData and rdBusy stay constant, with no shiftEn or latchOut activity; ack → IDLE next cycle.
- rstb pulsed low after the 17th shiftEn cycle → all outputs 0 immediately; after release, a new read of 0x12 returns 0xDEADBEEF correctly.
- Back-to-back reads of 0x00 (0xFFFFFFFF) then 0x01 (0x00000000) with rdReq continuously high and rdAck tied high → both words correct, and the second latchOut occurs 35 cycles after the first.
